// File: rtl/preamble_rate_detector.sv
// Recovers the transmitter's clock divider from the toggling training
// preamble. Half-bit run lengths are measured on the synchronized line,
// checked against the first run, averaged with rounding and presented as
// clk_div (average run minus one).
module preamble_rate_detector #(
    parameter int DIV_WIDTH  = 8,
    parameter int MEAS_COUNT = 8,
    parameter int TOL        = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 training,
    output logic [DIV_WIDTH-1:0] clk_div,
    output logic                 done,
    output logic                 error,
    output logic                 busy
);

    localparam int LOG2_MEAS = $clog2(MEAS_COUNT);
    localparam int RUN_W     = DIV_WIDTH + 1;
    localparam int SUM_W     = DIV_WIDTH + 1 + LOG2_MEAS;
    localparam int IDX_W     = $clog2(MEAS_COUNT + 1);

    // Longest legal run is 2^DIV_WIDTH cycles; one cycle more is a timeout.
    localparam logic [RUN_W-1:0] RUN_MAX  = {1'b1, {DIV_WIDTH{1'b0}}};
    localparam logic [RUN_W-1:0] RUN_SAT  = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] TOL_RUN  = RUN_W'(TOL);
    localparam logic [SUM_W-1:0] HALF     = SUM_W'(MEAS_COUNT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEAS_COUNT - 1);

    // Averaging uses a shift, so the run count must be a power of two.
    generate
        if (MEAS_COUNT < 2 || (MEAS_COUNT & (MEAS_COUNT - 1)) != 0) begin : g_bad_meas_count
            $error("preamble_rate_detector: MEAS_COUNT must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRST,
        S_MEAS,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state_reg, state_next;
    logic                 sync1_reg, sync2_reg, line_d_reg;
    logic                 line_edge;
    logic [RUN_W-1:0]     run_cnt_reg;
    logic [RUN_W-1:0]     ref_reg, ref_next;
    logic [SUM_W-1:0]     sum_reg, sum_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DIV_WIDTH-1:0] clk_div_reg, clk_div_next;
    logic [RUN_W-1:0]     run_diff;
    logic                 run_timeout;

    // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            line_d_reg <= 1'b1;
        end else begin
            sync1_reg  <= training;
            sync2_reg  <= sync1_reg;
            line_d_reg <= sync2_reg;
        end
    end

    assign line_edge = (sync2_reg != line_d_reg);

    // Run counter: restarts at 1 on every edge, otherwise counts up and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_reg <= '0;
        end else if (line_edge) begin
            run_cnt_reg <= RUN_W'(1);
        end else if (run_cnt_reg != RUN_SAT) begin
            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
        end
    end

    // The run being closed is the pre-update counter value.
    assign run_diff    = (run_cnt_reg >= ref_reg) ? (run_cnt_reg - ref_reg)
                                                  : (ref_reg - run_cnt_reg);
    assign run_timeout = !line_edge && (run_cnt_reg == RUN_MAX);

    // State and measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ref_reg     <= '0;
            sum_reg     <= '0;
            idx_reg     <= '0;
            clk_div_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ref_reg     <= ref_next;
            sum_reg     <= sum_next;
            idx_reg     <= idx_next;
            clk_div_reg <= clk_div_next;
        end
    end

    // Next-state and measurement datapath.
    always_comb begin
        state_next   = state_reg;
        ref_next     = ref_reg;
        sum_next     = sum_reg;
        idx_next     = idx_reg;
        clk_div_next = clk_div_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                // A falling edge (line was high, now low) opens the first run.
                if (line_edge && !sync2_reg) begin
                    state_next = S_FIRST;
                end
            end
            S_FIRST: begin
                if (line_edge) begin
                    ref_next   = run_cnt_reg;
                    sum_next   = SUM_W'(run_cnt_reg);
                    idx_next   = IDX_W'(1);
                    state_next = S_MEAS;
                end else if (run_timeout) begin
                    state_next = S_ERR;
                end
            end
            S_MEAS: begin
                if (line_edge) begin
                    if (run_diff > TOL_RUN) begin
                        state_next = S_ERR;
                    end else begin
                        sum_next = sum_reg + SUM_W'(run_cnt_reg);
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_reg == IDX_LAST) begin
                            state_next = S_DONE;
                        end
                    end
                end else if (run_timeout) begin
                    state_next = S_ERR;
                end
            end
            S_DONE: begin
                // Rounded average run length minus one; average is always >= 1.
                clk_div_next = DIV_WIDTH'(((sum_reg + HALF) >> LOG2_MEAS) - SUM_W'(1));
                state_next   = S_IDLE;
            end
            S_ERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign clk_div = clk_div_reg;
    assign done    = (state_reg == S_DONE);
    assign error   = (state_reg == S_ERR);
    assign busy    = (state_reg != S_IDLE);

endmodule
